// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with per-channel toggle/pulse output.
// Run-time divisor loads are applied at terminal count so a running period is never truncated.
module prog_clock_divider #(
  parameter  int WIDTH       = 32,
  parameter  int CHANNELS    = 4,
  parameter  int DEFAULT_DIV = 2500,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] mode,
  input  logic                load,
  input  logic [CW-1:0]       load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic                load_err,
  output logic [CHANNELS-1:0] clock_div,
  output logic [CHANNELS-1:0] tick
);

  logic w_load_ok;
  logic w_load_bad;
  logic r_load_err;

  assign w_load_ok  = load && (32'(load_ch) <  32'(CHANNELS));
  assign w_load_bad = load && (32'(load_ch) >= 32'(CHANNELS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_load_bad;
    end
  end

  assign load_err = r_load_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_active_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_valid;
    logic             r_clock_div;
    logic             r_tick;
    logic             w_hit;
    logic             w_tc;

    assign w_hit = w_load_ok && (load_ch == CW'(g));
    assign w_tc  = en[g] && (r_count == r_active_div);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_count      <= '0;
        r_active_div <= WIDTH'(DEFAULT_DIV);
        r_pend_div   <= WIDTH'(DEFAULT_DIV);
        r_pend_valid <= 1'b0;
        r_clock_div  <= 1'b0;
        r_tick       <= 1'b0;
      end else if (!en[g]) begin
        // Idle channel: a load takes effect at once and restarts the period.
        r_tick <= 1'b0;
        if (w_hit) begin
          r_active_div <= load_div;
          r_count      <= '0;
          r_pend_valid <= 1'b0;
        end
      end else if (w_tc) begin
        r_count     <= '0;
        r_tick      <= 1'b1;
        r_clock_div <= mode[g] ? 1'b1 : ~r_clock_div;
        if (w_hit) begin
          r_active_div <= load_div;
          r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
          r_active_div <= r_pend_div;
          r_pend_valid <= 1'b0;
        end
      end else begin
        r_count <= r_count + WIDTH'(1);
        r_tick  <= 1'b0;
        if (mode[g]) begin
          r_clock_div <= 1'b0;
        end
        if (w_hit) begin
          r_pend_div   <= load_div;
          r_pend_valid <= 1'b1;
        end
      end
    end

    assign clock_div[g] = r_clock_div;
    assign tick[g]      = r_tick;
  end

endmodule
